// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Zero-wait memory: rdata is valid in the same cycle that ready is high.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem handshake, one-entry skid buffer and IF/ID register.
// Redirects from execute flush IF/ID and skid; a stuck request is drained before retargeting.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               ex_valid,
    input  logic               Branch,
    input  logic               jump,
    input  logic               jr,
    input  logic               Zero,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ImmExt,
    input  logic [31:0]        rs1_data,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic [31:0]        instr_pc4,
    output logic               instr_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, drain_addr;
    logic [31:0] ifid_instr, ifid_pc;
    logic        ifid_valid;
    logic [31:0] skid_instr, skid_pc;
    logic        skid_valid;
    logic        req, redirect, fire;
    logic [31:0] addr, target, tgt_sum;

    assign redirect = ex_valid & ((Branch & Zero) | jump);
    assign tgt_sum  = jr ? (rs1_data + ImmExt) : (ex_pc + ImmExt);
    assign target   = {tgt_sum[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // The request is held through DRAIN at the old address because memory cannot abort it.
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        addr     = pc;
        case (state)
            IDLE:  state_nx = FETCH;
            FETCH: begin
                req = ~skid_valid;
                if (redirect && req && !imem.imem_ready) state_nx = DRAIN;
            end
            DRAIN: begin
                req  = 1'b1;
                addr = drain_addr;
                if (imem.imem_ready) state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;
    assign fire = (state == FETCH) & req & imem.imem_ready & ~redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= {RESET_PC[31:2], 2'b00};
            drain_addr <= {RESET_PC[31:2], 2'b00};
            ifid_instr <= NOP;
            ifid_pc    <= 32'h0;
            ifid_valid <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
            skid_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= target;
            ifid_valid <= 1'b0;
            skid_valid <= 1'b0;
            if (state == FETCH && state_nx == DRAIN) drain_addr <= pc;
        end else begin
            if (fire) pc <= pc + 32'd4;
            if (!ifid_valid || !stall) begin
                // Skid content is older than anything memory can return now.
                if (skid_valid) begin
                    ifid_instr <= skid_instr;
                    ifid_pc    <= skid_pc;
                    ifid_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (fire) begin
                    ifid_instr <= imem.imem_rdata;
                    ifid_pc    <= pc;
                    ifid_valid <= 1'b1;
                end else begin
                    ifid_valid <= 1'b0;
                end
            end else if (fire) begin
                skid_instr <= imem.imem_rdata;
                skid_pc    <= pc;
                skid_valid <= 1'b1;
            end
        end
    end

    assign instr       = ifid_valid ? ifid_instr : NOP;
    assign instr_pc    = ifid_pc;
    assign instr_pc4   = ifid_pc + 32'd4;
    assign instr_valid = ifid_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the memory model returns the request address as data.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, ex_valid, Branch, jump, jr, Zero, rdy;
    logic [31:0] ex_pc, ImmExt, rs1_data;
    logic [31:0] instr, instr_pc, instr_pc4;
    logic        instr_valid;
    int          ncmp = 0;
    int          nerr = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    fetch_stage_if bus();
    assign bus.imem_ready = rdy;
    assign bus.imem_rdata = bus.imem_addr;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem(bus.master), .stall(stall),
        .ex_valid(ex_valid), .Branch(Branch), .jump(jump), .jr(jr), .Zero(Zero),
        .ex_pc(ex_pc), .ImmExt(ImmExt), .rs1_data(rs1_data),
        .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4), .instr_valid(instr_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
        if (v) begin
            chk({tag, ".pc"},    instr_pc,  pc);
            chk({tag, ".instr"}, instr,     pc);
            chk({tag, ".pc4"},   instr_pc4, pc + 32'd4);
        end else begin
            chk({tag, ".nop"}, instr, NOP);
        end
    endtask

    task automatic chk_bus(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"},  {31'h0, bus.imem_req}, {31'h0, r});
        chk({tag, ".addr"}, bus.imem_addr, a);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ex;
        ex_valid = 0; Branch = 0; jump = 0; jr = 0; Zero = 0;
        ex_pc = 0; ImmExt = 0; rs1_data = 0;
    endtask

    initial begin
        rst_n = 0; stall = 0; rdy = 1;
        clr_ex();
        repeat (3) tick();
        chk_bus("reset", 1'b0, 32'h0);
        chk("reset.instr", instr, NOP);
        chk("reset.pc", instr_pc, 32'h0);
        chk("reset.pc4", instr_pc4, 32'h4);
        chk("reset.valid", {31'h0, instr_valid}, 32'h0);

        // Streaming with zero-wait memory.
        rst_n = 1;
        tick(); chk_bus("idle_exit", 1'b1, 32'h0); chk_if("idle_exit", 1'b0, 0);
        tick(); chk_if("s0", 1'b1, 32'h0); chk_bus("s0", 1'b1, 32'h4);
        for (int k = 1; k < 4; k++) begin
            tick(); chk_if("stream", 1'b1, 32'(k * 4));
        end
        tick(); chk_if("s10", 1'b1, 32'h10); chk_bus("s10", 1'b1, 32'h14);

        // Three stall cycles: 0x14 parks in the skid, no requests issued.
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick(); chk_if("stall", 1'b1, 32'h10); chk_bus("stall", 1'b0, 32'h18);
        end
        stall = 0;
        tick(); chk_if("unst14", 1'b1, 32'h14); chk_bus("unst14", 1'b1, 32'h18);
        tick(); chk_if("unst18", 1'b1, 32'h18); chk_bus("unst18", 1'b1, 32'h1C);

        // BEQ taken: 0x20 + 0x40.
        ex_valid = 1; Branch = 1; Zero = 1; ex_pc = 32'h20; ImmExt = 32'h40;
        tick(); chk_if("beq_flush", 1'b0, 0); chk_bus("beq_flush", 1'b1, 32'h60);
        clr_ex();
        tick(); chk_if("beq_tgt", 1'b1, 32'h60); chk_bus("beq_tgt", 1'b1, 32'h64);

        // BEQ not taken.
        ex_valid = 1; Branch = 1; Zero = 0; ex_pc = 32'h20; ImmExt = 32'h40;
        tick(); chk_if("beq_nt", 1'b1, 32'h64); chk_bus("beq_nt", 1'b1, 32'h68);
        clr_ex();

        // JALR: (0x103 + 2) & ~3 = 0x104.
        ex_valid = 1; jump = 1; jr = 1; rs1_data = 32'h103; ImmExt = 32'h2; ex_pc = 32'h20;
        tick(); chk_if("jalr_flush", 1'b0, 0); chk_bus("jalr_flush", 1'b1, 32'h104);
        clr_ex();
        tick(); chk_if("jalr_tgt", 1'b1, 32'h104); chk_bus("jalr_tgt", 1'b1, 32'h108);

        // Redirect during three wait states: old request drained, then target 0x210.
        rdy = 0;
        tick(); chk_if("wait1", 1'b0, 0); chk_bus("wait1", 1'b1, 32'h108);
        ex_valid = 1; jump = 1; ex_pc = 32'h200; ImmExt = 32'h10;
        tick(); chk_if("drain1", 1'b0, 0); chk_bus("drain1", 1'b1, 32'h108);
        clr_ex();
        tick(); chk_if("drain2", 1'b0, 0); chk_bus("drain2", 1'b1, 32'h108);
        rdy = 1;
        tick(); chk_if("drained", 1'b0, 0); chk_bus("drained", 1'b1, 32'h210);
        tick(); chk_if("drain_tgt", 1'b1, 32'h210); chk_bus("drain_tgt", 1'b1, 32'h214);

        // Asynchronous reset while a request waits.
        rdy = 0;
        tick(); chk_if("rw_pre", 1'b0, 0); chk_bus("rw_pre", 1'b1, 32'h214);
        #2 rst_n = 0;
        #1 chk_bus("rst_wait", 1'b0, 32'h0); chk_if("rst_wait", 1'b0, 0);
        #1 rst_n = 1; rdy = 1;
        tick(); chk_bus("rw_restart", 1'b1, 32'h0);
        tick(); chk_if("rw_first", 1'b1, 32'h0);

        // Asynchronous reset while stalled with a full skid.
        stall = 1;
        tick(); chk_if("rs_pre", 1'b1, 32'h0); chk_bus("rs_pre", 1'b0, 32'h8);
        #2 rst_n = 0;
        #1 chk_bus("rst_stall", 1'b0, 32'h0); chk_if("rst_stall", 1'b0, 0);
        chk("rst_stall.pc", instr_pc, 32'h0);
        #1 rst_n = 1; stall = 0;
        tick(); chk_bus("rs_restart", 1'b1, 32'h0);
        tick(); chk_if("rs_first", 1'b1, 32'h0);
        tick(); chk_if("rs_second", 1'b1, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
